// File: rtl/if_id_stage_if.sv
// IF/ID stage bus: fetch-side inputs, EX-side feedback and decoded ID outputs.
//
// Handshake: load_pc is the ready toward fetch (the IF instruction is taken
// and the PC advances on every edge where load_pc=1), id_issue is the valid
// toward EX (the decoded fields describe a real instruction only in a cycle
// where id_issue=1). There is no ready from EX; stalls are resolved here.
interface if_id_stage_if #(
    parameter int AW = 8,
    parameter int IW = 16
);
    // Fetch side
    logic [AW-1:0] pc_if;
    logic [AW-1:0] pc1_if;
    logic [IW-1:0] instr_if;
    logic          load_pc;
    logic [3:0]    branch_sel;

    // EX feedback
    logic          ex_valid;
    logic          ex_is_load;
    logic [2:0]    ex_rd;
    logic          ex_take_branch;
    logic          ex_take_ret;

    // ID outputs toward EX
    logic          id_issue;
    logic [AW-1:0] pc_id;
    logic [AW-1:0] pc1_id;
    logic [IW-1:0] instr_id;
    logic [2:0]    opcode_id;
    logic [1:0]    op_id;
    logic [2:0]    rn_id;
    logic [2:0]    rd_id;
    logic [1:0]    sh_id;
    logic [2:0]    rm_id;
    logic [AW-1:0] imm8_id;
    logic [AW-1:0] imm5_id;
    logic          halted;

    // The stage itself
    modport slave (
        input  pc_if, pc1_if, instr_if,
        input  ex_valid, ex_is_load, ex_rd, ex_take_branch, ex_take_ret,
        output load_pc, branch_sel, id_issue,
        output pc_id, pc1_id, instr_id,
        output opcode_id, op_id, rn_id, rd_id, sh_id, rm_id, imm8_id, imm5_id,
        output halted
    );

    // Whatever drives the stage (fetch + EX, or a testbench)
    modport master (
        output pc_if, pc1_if, instr_if,
        output ex_valid, ex_is_load, ex_rd, ex_take_branch, ex_take_ret,
        input  load_pc, branch_sel, id_issue,
        input  pc_id, pc1_id, instr_id,
        input  opcode_id, op_id, rn_id, rd_id, sh_id, rm_id, imm8_id, imm5_id,
        input  halted
    );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register and decode front end.
// Captures PC / PC+1 / instruction from fetch, slices the instruction into
// fields for EX, stalls on load-use hazards, flushes on EX redirects, and
// sequences the front end after reset and on HALT.
module if_id_stage #(
    parameter int AW = 8,
    parameter int IW = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    if_id_stage_if.slave bus,
    output logic [1:0] state_dbg,
    output logic       valid_dbg
);

    // Front-end sequencing states
    localparam logic [1:0] S_INIT = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_HALT = 2'b10;

    // One-hot next-PC selects toward fetch
    localparam logic [3:0] SEL_ZERO   = 4'b0001;
    localparam logic [3:0] SEL_PC1    = 4'b0010;
    localparam logic [3:0] SEL_BRANCH = 4'b0100;
    localparam logic [3:0] SEL_REG    = 4'b1000;

    // Opcodes that read registers, plus HALT
    localparam logic [2:0] OPC_BX   = 3'b010;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    logic [1:0]    state_q, state_d;
    logic          valid_q, valid_d;
    logic [AW-1:0] pc_id_q, pc_id_d;
    logic [AW-1:0] pc1_id_q, pc1_id_d;
    logic [IW-1:0] instr_id_q, instr_id_d;
    logic          halted_q, halted_d;

    // Field slices of the ID instruction
    logic [2:0] opcode_w;
    logic [1:0] op_w;
    logic [2:0] rn_w;
    logic [2:0] rd_w;
    logic [2:0] rm_w;

    assign opcode_w = instr_id_q[15:13];
    assign op_w     = instr_id_q[12:11];
    assign rn_w     = instr_id_q[10:8];
    assign rd_w     = instr_id_q[7:5];
    assign rm_w     = instr_id_q[2:0];

    logic use_rn;
    logic use_rd;
    logic use_rm;
    logic hazard;
    logic redirect;
    logic halt_hit;

    logic       load_pc_c;
    logic [3:0] branch_sel_c;
    logic       id_issue_c;

    // Register-read flags of the ID instruction, by opcode
    always_comb begin
        use_rn = 1'b0;
        use_rd = 1'b0;
        use_rm = 1'b0;
        case (opcode_w)
            OPC_ALU: begin
                use_rm = 1'b1;
                use_rn = (op_w != 2'b11);
            end
            OPC_MOV: begin
                use_rm = (op_w == 2'b00);
            end
            OPC_LDR: begin
                use_rn = 1'b1;
            end
            OPC_STR: begin
                use_rn = 1'b1;
                use_rd = 1'b1;
            end
            OPC_BX: begin
                use_rd = (op_w == 2'b00) || (op_w == 2'b10);
            end
            default: begin
                use_rn = 1'b0;
                use_rd = 1'b0;
                use_rm = 1'b0;
            end
        endcase
    end

    // A load in EX whose result the ID instruction reads needs one bubble
    always_comb begin
        hazard = valid_q & bus.ex_valid & bus.ex_is_load &
                 ((use_rn & (rn_w == bus.ex_rd)) |
                  (use_rm & (rm_w == bus.ex_rd)) |
                  (use_rd & (rd_w == bus.ex_rd)));
        redirect = bus.ex_take_ret | bus.ex_take_branch;
        halt_hit = valid_q & (opcode_w == OPC_HALT);
    end

    // Next-state, fetch control and ID register update
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        pc_id_d      = pc_id_q;
        pc1_id_d     = pc1_id_q;
        instr_id_d   = instr_id_q;
        halted_d     = halted_q;
        load_pc_c    = 1'b0;
        branch_sel_c = SEL_PC1;
        id_issue_c   = 1'b0;

        case (state_q)
            S_INIT: begin
                // Point fetch at address zero; nothing valid is in IF yet
                load_pc_c    = 1'b1;
                branch_sel_c = SEL_ZERO;
                valid_d      = 1'b0;
                state_d      = S_RUN;
            end
            S_RUN: begin
                if (redirect) begin
                    // Both the ID and IF instructions are wrong-path
                    load_pc_c    = 1'b1;
                    branch_sel_c = bus.ex_take_ret ? SEL_REG : SEL_BRANCH;
                    valid_d      = 1'b0;
                end else if (halt_hit) begin
                    // HALT retires here; fetch freezes for good
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else if (hazard) begin
                    // Hold fetch and ID; EX sees a bubble this cycle
                    load_pc_c = 1'b0;
                end else begin
                    load_pc_c  = 1'b1;
                    id_issue_c = valid_q;
                    pc_id_d    = bus.pc_if;
                    pc1_id_d   = bus.pc1_if;
                    instr_id_d = bus.instr_if;
                    valid_d    = 1'b1;
                end
            end
            S_HALT: begin
                load_pc_c = 1'b0;
            end
            default: begin
                state_d = S_INIT;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and ID registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_INIT;
            valid_q    <= 1'b0;
            pc_id_q    <= '0;
            pc1_id_q   <= '0;
            instr_id_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            pc_id_q    <= pc_id_d;
            pc1_id_q   <= pc1_id_d;
            instr_id_q <= instr_id_d;
            halted_q   <= halted_d;
        end
    end

    assign bus.load_pc    = load_pc_c;
    assign bus.branch_sel = branch_sel_c;
    assign bus.id_issue   = id_issue_c;
    assign bus.pc_id      = pc_id_q;
    assign bus.pc1_id     = pc1_id_q;
    assign bus.instr_id   = instr_id_q;
    assign bus.opcode_id  = opcode_w;
    assign bus.op_id      = op_w;
    assign bus.rn_id      = rn_w;
    assign bus.rd_id      = rd_w;
    assign bus.sh_id      = instr_id_q[4:3];
    assign bus.rm_id      = rm_w;
    assign bus.imm8_id    = AW'($signed(instr_id_q[7:0]));
    assign bus.imm5_id    = AW'($signed(instr_id_q[4:0]));
    assign bus.halted     = halted_q;

    assign state_dbg = state_q;
    assign valid_dbg = valid_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: reset sequencing, load-use stall,
// redirects, HALT, sign extension and asynchronous reset.
module tb_if_id_stage;

    localparam int AW = 8;
    localparam int IW = 16;

    logic       clk;
    logic       reset_n;
    logic [1:0] state_dbg;
    logic       valid_dbg;

    int n_checks;
    int n_fail;

    if_id_stage_if #(.AW(AW), .IW(IW)) bus ();

    if_id_stage #(.AW(AW), .IW(IW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .state_dbg (state_dbg),
        .valid_dbg (valid_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net against a hung run
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; returns at the following falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_if(input logic [AW-1:0] pc, input logic [IW-1:0] instr);
        bus.pc_if    = pc;
        bus.pc1_if   = pc + 8'd1;
        bus.instr_if = instr;
    endtask

    task automatic drive_ex(input logic v, input logic ld, input logic [2:0] rd,
                            input logic br, input logic ret);
        bus.ex_valid       = v;
        bus.ex_is_load     = ld;
        bus.ex_rd          = rd;
        bus.ex_take_branch = br;
        bus.ex_take_ret    = ret;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        drive_if(8'h00, 16'h0000);
        drive_ex(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state",  32'(state_dbg),      32'h0);
        chk("rst_valid",  32'(valid_dbg),      32'h0);
        chk("rst_pc_id",  32'(bus.pc_id),      32'h0);
        chk("rst_pc1_id", 32'(bus.pc1_id),     32'h0);
        chk("rst_instr",  32'(bus.instr_id),   32'h0);
        chk("rst_halted", 32'(bus.halted),     32'h0);

        // ---------------- reset release, cycle 0 ----------------
        reset_n = 1'b1;
        #1;
        chk("init_sel",   32'(bus.branch_sel), 32'h1);
        chk("init_ld",    32'(bus.load_pc),    32'h1);
        chk("init_issue", 32'(bus.id_issue),   32'h0);

        // Cycle 1: fetch presents PC 0
        tick();
        drive_if(8'h00, 16'hD105);
        #1;
        chk("run1_state", 32'(state_dbg),      32'h1);
        chk("run1_sel",   32'(bus.branch_sel), 32'h2);
        chk("run1_issue", 32'(bus.id_issue),   32'h0);
        chk("run1_ld",    32'(bus.load_pc),    32'h1);

        // Cycle 2: PC 0 in ID
        tick();
        drive_if(8'h01, 16'hA000);
        #1;
        chk("id0_issue",  32'(bus.id_issue),   32'h1);
        chk("id0_pc",     32'(bus.pc_id),      32'h0);
        chk("id0_pc1",    32'(bus.pc1_id),     32'h1);
        chk("id0_opcode", 32'(bus.opcode_id),  32'h6);
        chk("id0_op",     32'(bus.op_id),      32'h2);
        chk("id0_rn",     32'(bus.rn_id),      32'h1);
        chk("id0_imm8",   32'(bus.imm8_id),    32'h05);

        // PC 1 (A000) in ID; present A262 from IF
        tick();
        drive_if(8'h02, 16'hA262);
        #1;
        chk("id1_issue",  32'(bus.id_issue),   32'h1);
        chk("id1_opcode", 32'(bus.opcode_id),  32'h5);
        chk("id1_pc",     32'(bus.pc_id),      32'h1);

        // ---------------- load-use hazard ----------------
        tick();
        drive_if(8'h03, 16'h2000);
        drive_ex(1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
        #1;
        chk("hz_instr",   32'(bus.instr_id),   32'hA262);
        chk("hz_rn",      32'(bus.rn_id),      32'h2);
        chk("hz_rm",      32'(bus.rm_id),      32'h2);
        chk("hz_rd",      32'(bus.rd_id),      32'h3);
        chk("hz_ld",      32'(bus.load_pc),    32'h0);
        chk("hz_issue",   32'(bus.id_issue),   32'h0);
        chk("hz_sel",     32'(bus.branch_sel), 32'h2);

        // EX now has a load to r3: ALU does not read rd, so no stall
        tick();
        drive_ex(1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
        #1;
        chk("hz_hold_in", 32'(bus.instr_id),   32'hA262);
        chk("hz_hold_pc", 32'(bus.pc_id),      32'h2);
        chk("post_ld",    32'(bus.load_pc),    32'h1);
        chk("post_issue", 32'(bus.id_issue),   32'h1);

        // ---------------- branch redirect ----------------
        tick();
        drive_if(8'h04, 16'h8000);
        drive_ex(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        #1;
        chk("br_id_pc",   32'(bus.pc_id),      32'h3);
        chk("br_sel",     32'(bus.branch_sel), 32'h4);
        chk("br_ld",      32'(bus.load_pc),    32'h1);
        chk("br_issue",   32'(bus.id_issue),   32'h0);

        tick();
        drive_if(8'h40, 16'h4060);
        drive_ex(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        #1;
        chk("br_flush_v", 32'(valid_dbg),      32'h0);
        chk("br_flush_i", 32'(bus.id_issue),   32'h0);
        chk("br_next_sel",32'(bus.branch_sel), 32'h2);

        // ---------------- redirect beats hazard ----------------
        // BX r3 in ID reads rd; a load to r3 in EX would stall it
        tick();
        drive_if(8'h41, 16'h0000);
        drive_ex(1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
        #1;
        chk("rbh_instr",  32'(bus.instr_id),   32'h4060);
        chk("rbh_ld",     32'(bus.load_pc),    32'h1);
        chk("rbh_sel",    32'(bus.branch_sel), 32'h4);
        chk("rbh_issue",  32'(bus.id_issue),   32'h0);

        // Return wins over branch
        tick();
        drive_ex(1'b1, 1'b1, 3'd3, 1'b1, 1'b1);
        #1;
        chk("rbh_flush",  32'(valid_dbg),      32'h0);
        chk("ret_sel",    32'(bus.branch_sel), 32'h8);
        chk("ret_issue",  32'(bus.id_issue),   32'h0);

        // ---------------- sign extension ----------------
        tick();
        drive_ex(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        drive_if(8'h50, 16'h0013);
        tick();
        drive_if(8'h51, 16'hE000);
        #1;
        chk("sx_issue",   32'(bus.id_issue),   32'h1);
        chk("sx_imm5",    32'(bus.imm5_id),    32'hF3);
        chk("sx_imm8",    32'(bus.imm8_id),    32'h13);
        chk("sx_sh",      32'(bus.sh_id),      32'h2);

        // ---------------- HALT ----------------
        tick();
        drive_if(8'h52, 16'h0000);
        #1;
        chk("halt_opc",   32'(bus.opcode_id),  32'h7);
        chk("halt_ld0",   32'(bus.load_pc),    32'h0);
        chk("halt_iss0",  32'(bus.id_issue),   32'h0);
        chk("halt_pre",   32'(bus.halted),     32'h0);

        tick();
        #1;
        chk("halted",     32'(bus.halted),     32'h1);
        chk("halt_state", 32'(state_dbg),      32'h2);
        chk("halt_ld1",   32'(bus.load_pc),    32'h0);
        chk("halt_sel",   32'(bus.branch_sel), 32'h2);

        repeat (3) tick();
        #1;
        chk("halt_stay",  32'(bus.halted),     32'h1);
        chk("halt_ld2",   32'(bus.load_pc),    32'h0);
        chk("halt_instr", 32'(bus.instr_id),   32'hE000);

        // ---------------- async reset between edges ----------------
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_halted",  32'(bus.halted),     32'h0);
        chk("ar_valid",   32'(valid_dbg),      32'h0);
        chk("ar_instr",   32'(bus.instr_id),   32'h0);
        chk("ar_state",   32'(state_dbg),      32'h0);
        chk("ar_sel",     32'(bus.branch_sel), 32'h1);

        // Init sequence repeats
        @(negedge clk);
        drive_if(8'h00, 16'h0000);
        reset_n = 1'b1;
        #1;
        chk("re_sel0",    32'(bus.branch_sel), 32'h1);
        chk("re_ld0",     32'(bus.load_pc),    32'h1);
        tick();
        drive_if(8'h00, 16'hD105);
        #1;
        chk("re_sel1",    32'(bus.branch_sel), 32'h2);
        chk("re_issue1",  32'(bus.id_issue),   32'h0);
        tick();
        drive_if(8'h01, 16'hA000);
        #1;
        chk("re_issue2",  32'(bus.id_issue),   32'h1);
        chk("re_instr",   32'(bus.instr_id),   32'hD105);

        // Async reset while a valid instruction sits in ID
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar2_valid",  32'(valid_dbg),      32'h0);
        chk("ar2_instr",  32'(bus.instr_id),   32'h0);
        chk("ar2_pc1",    32'(bus.pc1_id),     32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
